// File: rtl/nios_setup_v2_button_pio_pkg.sv
// Register offsets and edge-type codes shared by the Nios PIO peripherals.
package nios_setup_v2_button_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_setup_v2_pio_edge_detect.sv
// Synchroniser chain for asynchronous PIO inputs, plus a one-cycle delay
// flop and the per-bit edge qualifier selected by EDGE_TYPE.
module nios_setup_v2_pio_edge_detect
    import nios_setup_v2_button_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_det_o
);

    logic [WIDTH-1:0] sync_chain_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // NOTE: every flop here uses <= and clears on the async reset, so prev_q and
    // sync_o both restart at 0 and a high input reads as a rising edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_chain_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_chain_q[0] <= in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_chain_q[i] <= sync_chain_q[i-1];
            prev_q <= sync_chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_chain_q[SYNC_STAGES-1];

    always_comb begin
        edge_det_o = sync_o ^ prev_q;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_det_o = sync_o & ~prev_q;
            EDGE_FALLING: edge_det_o = ~sync_o & prev_q;
            default:      edge_det_o = sync_o ^ prev_q;
        endcase
    end

endmodule

// File: rtl/nios_setup_v2_button_pio.sv
// Avalon-MM input PIO: synchronised DATA, IRQMASK, sticky W1C EDGECAPTURE and
// a level irq; zero-wait-state writes, read latency 0.
module nios_setup_v2_button_pio
    import nios_setup_v2_button_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] cap_clear;
    logic             wr_en;
    logic [31:0]      wdata_unused;

    nios_setup_v2_pio_edge_detect #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_detect (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_i       (in_port),
        .sync_o     (sync_q),
        .edge_det_o (edge_det)
    );

    assign wr_en        = chipselect && !write_n;
    assign wdata_unused = writedata;

    always_comb begin
        irqmask_d = irqmask_q;
        cap_clear = '0;
        if (wr_en && (address == PIO_ADDR_IRQMASK)) irqmask_d = writedata[WIDTH-1:0];
        if (wr_en && (address == PIO_ADDR_EDGECAP)) cap_clear = writedata[WIDTH-1:0];
        // A new edge outranks a same-cycle clear so no event is ever lost.
        edgecap_d = edge_det | (edgecap_q & ~cap_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // NOTE: readdata is assigned a default before the case so no latch is inferred.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_setup_v2_button_pio.sv
// Scoreboard bench: three DUTs (rising/falling/any edge) share one stimulus
// stream; a history-based reference model predicts readdata and irq per cycle.
module tb_nios_setup_v2_button_pio;
    import nios_setup_v2_button_pio_pkg::*;

    localparam int W = 4;
    localparam int S = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [W-1:0]     in_port;
    logic [2:0][31:0] rdata;
    logic [2:0]       irq_w;

    always #5 clk = ~clk;

    nios_setup_v2_button_pio #(.WIDTH(W), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(S)) u_dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[0]), .irq(irq_w[0])
    );
    nios_setup_v2_button_pio #(.WIDTH(W), .EDGE_TYPE(EDGE_FALLING), .SYNC_STAGES(S)) u_dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[1]), .irq(irq_w[1])
    );
    nios_setup_v2_button_pio #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S)) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[2]), .irq(irq_w[2])
    );

    typedef struct {
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: hist[k] is the in_port value sampled k posedges ago.
    logic [W-1:0] hist [S+2];
    logic [W-1:0] mask_m;
    logic [W-1:0] cap_m [3];
    logic [W-1:0] cur_in;

    function automatic logic [W-1:0] edges_seen(int kind, logic [W-1:0] now_v, logic [W-1:0] before_v);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            if (now_v[b] != before_v[b]) begin
                if (kind == 2) r[b] = 1'b1;
                else if (kind == 0 && now_v[b]) r[b] = 1'b1;
                else if (kind == 1 && !now_v[b]) r[b] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < S + 2; i++) hist[i] = '0;
        mask_m = '0;
        for (int t = 0; t < 3; t++) cap_m[t] = '0;
    endtask

    task automatic model_posedge();
        logic [W-1:0] clr;
        if (!reset_n) begin
            model_clear();
        end else begin
            for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = in_port;
            clr = '0;
            if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
            if (chipselect && !write_n && address == 2'd2) mask_m = writedata[W-1:0];
            // Capture reflects the edge visible on the synchronised value one cycle earlier.
            for (int t = 0; t < 3; t++)
                cap_m[t] = edges_seen(t, hist[S], hist[S+1]) | (cap_m[t] & ~clr);
        end
    endtask

    task automatic push_expected(input string tag);
        exp_t e;
        logic [W-1:0] v;
        for (int t = 0; t < 3; t++) begin
            case (address)
                2'd0:    v = hist[S-1];
                2'd2:    v = mask_m;
                2'd3:    v = cap_m[t];
                default: v = '0;
            endcase
            e.rd[t]  = 32'(v);
            e.irq[t] = |(cap_m[t] & mask_m);
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input logic rn, input logic cs, input logic wn, input logic [1:0] ad,
                        input logic [31:0] wd, input string tag);
        @(posedge clk);
        model_posedge();
        #1;
        reset_n    = rn;
        chipselect = cs;
        write_n    = wn;
        address    = ad;
        writedata  = wd;
        in_port    = cur_in;
        if (!rn) model_clear();
        push_expected(tag);
    endtask

    task automatic idle(input int n, input logic [1:0] ad, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, ad, 32'h0, tag);
    endtask

    task automatic wr(input logic [1:0] ad, input logic [31:0] wd, input string tag);
        step(1'b1, 1'b1, 1'b0, ad, wd, tag);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int t = 0; t < 3; t++) begin
                check($sformatf("%s rd[type%0d]", e.tag, t), rdata[t], e.rd[t]);
                check($sformatf("%s irq[type%0d]", e.tag, t), 32'(irq_w[t]), 32'(e.irq[t]));
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        cur_in     = 4'b1010;
        in_port    = cur_in;
        model_clear();

        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, "reset_hold");
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, "reset_hold");
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, "reset_hold");
        idle(4, 2'd0, "post_reset_data");
        idle(1, 2'd3, "post_reset_cap");

        wr(2'd2, 32'hF, "mask_all");
        wr(2'd3, 32'hF, "clear_all");
        idle(3, 2'd3, "quiet");

        cur_in = 4'b1110;
        idle(4, 2'd3, "rise_bit2");
        wr(2'd3, 32'h2, "w1c_other_bit");
        idle(1, 2'd3, "bit2_kept");
        wr(2'd3, 32'h4, "w1c_bit2");
        idle(2, 2'd3, "bit2_cleared");

        cur_in = 4'b1111;
        idle(2, 2'd3, "rise_bit0");
        wr(2'd3, 32'h1, "collide_bit0");
        idle(2, 2'd3, "collide_after");

        wr(2'd2, 32'h0, "mask_none");
        wr(2'd3, 32'hF, "clear_all2");
        cur_in = 4'b1101;
        idle(4, 2'd3, "fall_bit1");
        cur_in = 4'b1111;
        idle(4, 2'd3, "rise_bit1");
        wr(2'd2, 32'h2, "mask_bit1");
        idle(1, 2'd3, "irq_unmasked");
        idle(1, 2'd2, "read_mask");
        idle(1, 2'd1, "read_rsvd");
        wr(2'd1, 32'hFFFF_FFFF, "write_rsvd");
        wr(2'd0, 32'hFFFF_FFFF, "write_data");
        idle(1, 2'd1, "read_rsvd2");

        wr(2'd2, 32'hF, "mask_all2");
        wr(2'd3, 32'hF, "clear_all3");
        cur_in = 4'b0111;
        idle(4, 2'd3, "bit3_low");
        wr(2'd3, 32'hF, "clear_all4");
        cur_in = 4'b1111;
        idle(3, 2'd3, "pulse_bit3");
        cur_in = 4'b0111;
        idle(4, 2'd3, "pulse_end");
        cur_in = 4'b1111;
        idle(2, 2'd3, "pulse2_bit3");
        step(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, "reset_mid_cap");
        step(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, "reset_mid_mask");
        idle(4, 2'd0, "after_mid_reset");

        for (int i = 0; i < 400; i++) begin
            logic        rn;
            logic        cs;
            logic        wn;
            logic [1:0]  ad;
            logic [31:0] wd;
            if ($urandom_range(0, 3) == 0) cur_in = cur_in ^ W'($urandom_range(1, 15));
            rn = ($urandom_range(0, 149) != 0);
            cs = $urandom_range(0, 1) == 1;
            wn = $urandom_range(0, 2) != 0;
            ad = 2'($urandom_range(0, 3));
            wd = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 15)) : $urandom;
            step(rn, cs, wn, ad, wd, "random");
        end

        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
